// File: rtl/pulse_fifo_arb.sv
// Per-channel timestamped pulse FIFOs merged by a round-robin arbiter into one registered output stream.
// Define PULSE_FIFO_DROP_CNT_EN to enable the saturating rejected-write counter on drop_count.
module pulse_fifo_arb #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CH_BITS  = 2,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PTR_BITS = 4,
    parameter int unsigned TS_BITS  = 32,
    parameter int unsigned LEN_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*TS_BITS-1:0]  in_ts,
    input  logic [CHANNELS*LEN_BITS-1:0] in_length,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [TS_BITS-1:0]           out_ts,
    output logic [LEN_BITS-1:0]          out_length,
    output logic [CH_BITS-1:0]           out_channel,
    input  logic                         out_ready,
    output logic [15:0]                  drop_count
);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [TS_BITS-1:0]  ts_mem  [CHANNELS][DEPTH];
    logic [LEN_BITS-1:0] len_mem [CHANNELS][DEPTH];
    logic [PTR_BITS-1:0] wr_ptr  [CHANNELS];
    logic [PTR_BITS-1:0] rd_ptr  [CHANNELS];
    logic [CNT_BITS-1:0] count   [CHANNELS];
    logic [CH_BITS-1:0]  last_grant;

    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] non_empty;
    logic                loadable;
    logic                grant_found;
    logic [CH_BITS-1:0]  grant_ch;
    logic [CH_BITS-1:0]  cand;
    logic [TS_BITS-1:0]  head_ts;
    logic [LEN_BITS-1:0] head_len;

    // Full channels refuse input even while being read; nothing is accepted during reset.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c]  = (count[c] != CNT_BITS'(DEPTH)) && !reset;
            push[c]      = in_valid[c] && in_ready[c];
            non_empty[c] = (count[c] != '0);
        end
    end

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        loadable    = !out_valid || out_ready;
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = CH_BITS'((32'(last_grant) + 32'(i)) % CHANNELS);
            if (!grant_found && non_empty[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            pop[c] = loadable && grant_found && (grant_ch == CH_BITS'(c));
        end
        head_ts  = ts_mem[grant_ch][rd_ptr[grant_ch]];
        head_len = len_mem[grant_ch][rd_ptr[grant_ch]];
    end

    // Storage arrays carry no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                ts_mem[c][wr_ptr[c]]  <= in_ts[c*TS_BITS +: TS_BITS];
                len_mem[c][wr_ptr[c]] <= in_length[c*LEN_BITS +: LEN_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
            last_grant  <= CH_BITS'(CHANNELS - 1);
            out_valid   <= 1'b0;
            out_ts      <= '0;
            out_length  <= '0;
            out_channel <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PTR_BITS'(1);
                end
                if (pop[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PTR_BITS'(1);
                end
                if (push[c] && !pop[c]) begin
                    count[c] <= count[c] + CNT_BITS'(1);
                end else if (!push[c] && pop[c]) begin
                    count[c] <= count[c] - CNT_BITS'(1);
                end
            end
            if (loadable) begin
                out_valid <= grant_found;
                if (grant_found) begin
                    out_ts      <= head_ts;
                    out_length  <= head_len;
                    out_channel <= grant_ch;
                    last_grant  <= grant_ch;
                end
            end
        end
    end

`ifdef PULSE_FIFO_DROP_CNT_EN
    logic [CH_BITS:0] drops;
    logic [16:0]      drop_sum;

    // One count per refused channel per cycle, saturating.
    always_comb begin
        drops = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            drops = drops + (CH_BITS+1)'(in_valid[c] && !in_ready[c]);
        end
        drop_sum = 17'(drop_count) + 17'(drops);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pulse_fifo_arb.sv
// Directed bench for pulse_fifo_arb: a record scoreboard checks every completed output transfer,
// directed steps check latency, backpressure, arbitration order, full/drop and reset behaviour.
module tb_pulse_fifo_arb;
    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    in_valid;
    logic [127:0]  in_ts;
    logic [63:0]   in_length;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [31:0]   out_ts;
    logic [15:0]   out_length;
    logic [1:0]    out_channel;
    logic          out_ready;
    logic [15:0]   drop_count;

`ifdef PULSE_FIFO_DROP_CNT_EN
    localparam int unsigned EXP_DROP = 1;
`else
    localparam int unsigned EXP_DROP = 0;
`endif

    typedef struct packed {
        logic [1:0]  ch;
        logic [31:0] ts;
        logic [15:0] len;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   xfers  = 0;

    pulse_fifo_arb dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ts      (in_ts),
        .in_length  (in_length),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ts     (out_ts),
        .out_length (out_length),
        .out_channel(out_channel),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one record on channel c; accept says whether the bench expects the FIFO to take it.
    task automatic put(input int c, input logic [31:0] ts, input logic [15:0] len, input bit accept);
        rec_t r;
        in_valid[c] = 1'b1;
        in_ts[c*32 +: 32] = ts;
        in_length[c*16 +: 16] = len;
        check($sformatf("in_ready_ch%0d", c), 64'(in_ready[c]), 64'(accept));
        if (accept) begin
            r.ch  = 2'(c);
            r.ts  = ts;
            r.len = len;
            sb.push_back(r);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_ts", 64'(out_ts), 64'(0));
        check("rst_out_length", 64'(out_length), 64'(0));
        check("rst_out_channel", 64'(out_channel), 64'(0));
        check("rst_drop_count", 64'(drop_count), 64'(0));
        reset = 1'b0;
        tick();
        check("post_rst_in_ready", 64'(in_ready), 64'(4'hF));
        sb.delete();
    endtask

    // Accept everything until n more transfers complete and the output goes idle.
    task automatic drain(input string tag, input int n);
        int start;
        int cyc;
        start = xfers;
        cyc = 0;
        out_ready = 1'b1;
        while ((out_valid || (xfers - start) < n) && cyc < 200) begin
            tick();
            cyc++;
        end
        check({tag, "_timeout"}, 64'(cyc < 200), 64'(1));
        check({tag, "_count"}, 64'(xfers - start), 64'(n));
    endtask

    // Scoreboard: each completed transfer must match the oldest pending record of its channel.
    always @(negedge clk) begin
        int idx;
        if (!reset && out_valid && out_ready) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].ch == out_channel) idx = i;
            end
            check("sb_expected_record", 64'(idx >= 0), 64'(1));
            if (idx >= 0) begin
                check("sb_ts", 64'(out_ts), 64'(sb[idx].ts));
                check("sb_length", 64'(out_length), 64'(sb[idx].len));
                sb.delete(idx);
            end
            xfers++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        stalled;
        logic [31:0] p_ts;
        logic [15:0] p_len;
        logic [1:0]  p_ch;

        reset = 1'b1;
        in_valid = '0;
        in_ts = '0;
        in_length = '0;
        out_ready = 1'b0;

        // Single record latency: valid exactly one cycle after acceptance, for one cycle.
        do_reset();
        out_ready = 1'b1;
        put(0, 32'h100, 16'd5, 1'b1);
        tick();
        in_valid = '0;
        check("lat_edge_k_valid", 64'(out_valid), 64'(0));
        tick();
        check("lat_edge_k1_valid", 64'(out_valid), 64'(1));
        check("lat_ts", 64'(out_ts), 64'(32'h100));
        check("lat_length", 64'(out_length), 64'(5));
        check("lat_channel", 64'(out_channel), 64'(0));
        tick();
        check("lat_edge_k2_valid", 64'(out_valid), 64'(0));

        // Fill ch2 with the output stalled; the output register holds one, so 17 fit.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            put(2, 32'h200 + 32'(i), 16'(i), 1'b1);
            tick();
        end
        check("full_in_ready", 64'(in_ready), 64'(4'b1011));
        put(2, 32'h2FF, 16'hFFFF, 1'b0);
        tick();
        in_valid = '0;
        check("full_drop_count", 64'(drop_count), 64'(EXP_DROP));
        check("full_still_blocked", 64'(in_ready), 64'(4'b1011));
        out_ready = 1'b1;
        tick();
        check("full_ready_after_pop", 64'(in_ready), 64'(4'hF));
        drain("full_drain", 16);
        check("full_sb_empty", 64'(sb.size()), 64'(0));

        // Round-robin order with all channels loaded, no idle cycles.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) put(c, 32'h3000 + 32'(c*16 + r), 16'(r), 1'b1);
            tick();
        end
        in_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("rr_valid_%0d", i), 64'(out_valid), 64'(1));
            check($sformatf("rr_channel_%0d", i), 64'(out_channel), 64'(i % 4));
            tick();
        end
        check("rr_idle_after", 64'(out_valid), 64'(0));
        check("rr_sb_empty", 64'(sb.size()), 64'(0));

        // Toggled backpressure with continuous ch1 traffic: stalled fields must hold.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            put(1, 32'h4000 + 32'(i), 16'(100 + i), 1'b1);
            stalled = out_valid && !out_ready;
            p_ts = out_ts;
            p_len = out_length;
            p_ch = out_channel;
            tick();
            in_valid = '0;
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_ts", 64'(out_ts), 64'(p_ts));
                check("stall_length", 64'(out_length), 64'(p_len));
                check("stall_channel", 64'(out_channel), 64'(p_ch));
            end
        end
        drain("stall_drain", sb.size());
        check("stall_sb_empty", 64'(sb.size()), 64'(0));

        // Steady simultaneous write/read on ch3 with 8 entries buffered plus one held in the output.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            put(3, 32'h5000 + 32'(i), 16'(i), 1'b1);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 9; i < 19; i++) begin
            put(3, 32'h5000 + 32'(i), 16'(i), 1'b1);
            tick();
        end
        in_valid = '0;
        check("rw_in_ready", 64'(in_ready), 64'(4'hF));
        drain("rw_drain", 9);
        check("rw_sb_empty", 64'(sb.size()), 64'(0));

        // Reset with a held record and five queued: everything is discarded.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            put(0, 32'h6000 + 32'(r), 16'(r), 1'b1);
            put(1, 32'h6100 + 32'(r), 16'(r), 1'b1);
            tick();
        end
        in_valid = '0;
        check("mid_out_valid", 64'(out_valid), 64'(1));
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("no_stale_valid", 64'(out_valid), 64'(0));
        end
        check("final_sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
